// File: rtl/gb_timer.sv
// Game Boy timer block: DIV/TIMA/TMA/TAC registers, the free-running 16-bit
// system counter, and a TIMA overflow sequencer that drives the timer IRQ.
module gb_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic        bus_enable,
  input  logic        bus_write,
  input  logic        bus_commit,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_selected,
  output logic        irq_timer
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  logic [15:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        s_q;
  logic        irq_q, irq_d;

  logic [15:0] offs;
  logic        wr, wr_div, wr_tima, wr_tma, wr_tac;
  logic        sel_bit, s, fall;

  assign offs         = bus_addr - BASE_ADDR;
  assign bus_selected = bus_enable & (offs < 16'd4);
  assign wr           = bus_commit & bus_selected & bus_write;
  assign wr_div       = wr & (offs[1:0] == 2'd0);
  assign wr_tima      = wr & (offs[1:0] == 2'd1);
  assign wr_tma       = wr & (offs[1:0] == 2'd2);
  assign wr_tac       = wr & (offs[1:0] == 2'd3);
  assign irq_timer    = irq_q;

  // Pick the system-counter tap selected by TAC and gate it with the enable.
  always_comb begin
    sel_bit = 1'b0;
    unique case (tac_q[1:0])
      2'b00: sel_bit = sys_cnt_q[9];
      2'b01: sel_bit = sys_cnt_q[3];
      2'b10: sel_bit = sys_cnt_q[5];
      2'b11: sel_bit = sys_cnt_q[7];
    endcase
    s    = tac_q[2] & sel_bit;
    fall = s_q & ~s;
  end

  // Register read mux; unselected accesses float high like an open bus.
  always_comb begin
    bus_rdata = 8'hFF;
    if (bus_selected) begin
      unique case (offs[1:0])
        2'd0: bus_rdata = sys_cnt_q[15:8];
        2'd1: bus_rdata = tima_q;
        2'd2: bus_rdata = tma_q;
        2'd3: bus_rdata = {5'b11111, tac_q};
      endcase
    end
  end

  // Next-state: register writes, TIMA increment and the overflow sequencer.
  // Writes that move the tap low are seen as falling edges on the next clk,
  // which reproduces the DMG glitch increments without extra logic.
  always_comb begin
    sys_cnt_d = sys_cnt_q + 16'd1;
    tima_d    = tima_q;
    tma_d     = tma_q;
    tac_d     = tac_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    irq_d     = 1'b0;

    if (wr_div) sys_cnt_d = '0;
    if (wr_tac) tac_d = bus_wdata[2:0];
    if (wr_tma) tma_d = bus_wdata;

    case (state_q)
      ST_RUN: begin
        if (wr_tima) begin
          tima_d = bus_wdata;
        end else if (fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = '0;
            state_d = ST_DELAY;
            cnt_d   = 2'd3;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_DELAY: begin
        if (wr_tima) begin
          // A CPU write during the delay window cancels the reload and IRQ.
          tima_d  = bus_wdata;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == 2'd0) begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = ST_RELOAD;
          cnt_d   = 2'd3;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RELOAD: begin
        if (wr_tma) tima_d = bus_wdata;
        if (cnt_q == 2'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sys_cnt_q <= '0;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: register table vectors plus scoreboarded sequences for
// counter rate, overflow/reload timing, write races, glitches and reset.
module tb_gb_timer;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic        bus_enable, bus_write, bus_commit;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_selected;
  logic        irq_timer;

  int checks = 0;
  int errors = 0;

  gb_timer #(.BASE_ADDR(16'hFF04)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_enable(bus_enable),
    .bus_write(bus_write), .bus_commit(bus_commit), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_selected(bus_selected), .irq_timer(irq_timer)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    bit          is_irq;
    logic [15:0] addr;
    logic [7:0]  val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    bit          do_wr;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] raddr;
    bit          ren;
    logic        exp_sel;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t vt[10];

  function automatic vec_t mk(string n, bit w, logic [15:0] wa, logic [7:0] wd,
                              logic [15:0] ra, bit en, logic es, logic [7:0] er);
    vec_t v;
    v.name = n; v.do_wr = w; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.ren = en; v.exp_sel = es; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_addr = a; bus_enable = 1'b1; bus_write = 1'b0;
    #1;
    d = bus_rdata;
    bus_enable = 1'b0;
  endtask

  // Drives one write that commits on the next rising edge, returns 1 after it.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d;
    bus_enable = 1'b1; bus_write = 1'b1; bus_commit = 1'b1;
    @(posedge clk);
    #1;
    bus_enable = 1'b0; bus_write = 1'b0; bus_commit = 1'b0;
  endtask

  task automatic exp_rd(input string n, input logic [15:0] a, input logic [7:0] v);
    exp_t e;
    e.name = n; e.is_irq = 1'b0; e.addr = a; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic exp_irq(input string n, input logic v);
    exp_t e;
    e.name = n; e.is_irq = 1'b1; e.addr = '0; e.val = {7'b0, v};
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] d;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.is_irq) begin
        chk(e.name, {7'b0, irq_timer}, e.val);
      end else begin
        rd(e.addr, d);
        chk(e.name, d, e.val);
      end
    end
  endtask

  // Timer off, TIMA preset, DIV cleared: sys_counter is 0 after the return.
  task automatic align(input logic [7:0] tima0);
    wr(A_TAC, 8'h00);
    wr(A_TIMA, tima0);
    wr(A_DIV, 8'h00);
  endtask

  // TMA=AB, TIMA=FF, TAC=05 enabled at counter edge 1; overflow lands on E17.
  task automatic ovf_start();
    wr(A_TMA, 8'hAB);
    align(8'hFF);
    wr(A_TAC, 8'h05);
  endtask

  initial begin
    logic [7:0] d;
    bus_addr = '0; bus_enable = 1'b0; bus_write = 1'b0;
    bus_commit = 1'b0; bus_wdata = '0;
    reset = 1'b1;

    // Outputs while reset is held
    #2;
    exp_irq("rst_irq", 1'b0);
    exp_rd("rst_div", A_DIV, 8'h00);
    exp_rd("rst_tac", A_TAC, 8'hF8);
    drain();
    tick(3);
    reset = 1'b0;

    // DIV rolls at 256 clocks and wraps after 65536
    tick(255); exp_rd("div_255", A_DIV, 8'h00); drain();
    tick();    exp_rd("div_256", A_DIV, 8'h01); drain();
    tick(65279); exp_rd("div_65535", A_DIV, 8'hFF); drain();
    tick();    exp_rd("div_wrap", A_DIV, 8'h00); drain();

    // Register access table
    vt[0] = mk("tma_5a",     1, A_TMA,  8'h5A, A_TMA,       1, 1'b1, 8'h5A);
    vt[1] = mk("tma_a5",     1, A_TMA,  8'hA5, A_TMA,       1, 1'b1, 8'hA5);
    vt[2] = mk("tac_03",     1, A_TAC,  8'h03, A_TAC,       1, 1'b1, 8'hFB);
    vt[3] = mk("tac_f8",     1, A_TAC,  8'hF8, A_TAC,       1, 1'b1, 8'hF8);
    vt[4] = mk("tima_3c",    1, A_TIMA, 8'h3C, A_TIMA,      1, 1'b1, 8'h3C);
    vt[5] = mk("below_base", 0, A_TMA,  8'h00, 16'hFF03,    1, 1'b0, 8'hFF);
    vt[6] = mk("above_top",  0, A_TMA,  8'h00, 16'hFF08,    1, 1'b0, 8'hFF);
    vt[7] = mk("disabled",   0, A_TMA,  8'h00, A_TMA,       0, 1'b0, 8'hFF);
    vt[8] = mk("wr_outside", 1, 16'hFF08, 8'h00, A_TMA,     1, 1'b1, 8'hA5);
    vt[9] = mk("tac_0b",     1, A_TAC,  8'h0B, A_TAC,       1, 1'b1, 8'hFB);
    for (int i = 0; i < 10; i++) begin
      if (vt[i].do_wr) wr(vt[i].waddr, vt[i].wdata);
      bus_addr = vt[i].raddr; bus_enable = vt[i].ren; bus_write = 1'b0;
      #1;
      chk({vt[i].name, "_sel"}, {7'b0, bus_selected}, {7'b0, vt[i].exp_sel});
      chk({vt[i].name, "_rd"}, bus_rdata, vt[i].exp_rd);
      bus_enable = 1'b0;
      tick();
    end

    // TAC=05: one increment per 16 clocks, first at edge 17
    align(8'h00); wr(A_TAC, 8'h05);
    tick(15);  exp_rd("rate16_e16", A_TIMA, 8'h00); drain();
    tick();    exp_rd("rate16_e17", A_TIMA, 8'h01); drain();
    tick(143); exp_rd("rate16_e160", A_TIMA, 8'h09); drain();
    tick();    exp_rd("rate16_e161", A_TIMA, 8'h0A); drain();
    // TIMA write on the same edge as an increment wins
    tick(15);  wr(A_TIMA, 8'h40);
    exp_rd("race_write_wins", A_TIMA, 8'h40); drain();
    tick(16);  exp_rd("race_next_inc", A_TIMA, 8'h41); drain();

    // TAC=04: one increment per 1024 clocks
    align(8'h00); wr(A_TAC, 8'h04);
    tick(1023); exp_rd("rate1k_e1024", A_TIMA, 8'h00); drain();
    tick();     exp_rd("rate1k_e1025", A_TIMA, 8'h01); drain();

    // Overflow: 4 clocks of 00, then TMA with a single IRQ clock
    ovf_start();
    tick(15);
    exp_irq("ovf_pre_irq", 1'b0); exp_rd("ovf_pre", A_TIMA, 8'hFF); drain();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_irq("ovf_delay_irq", 1'b0); exp_rd("ovf_delay_tima", A_TIMA, 8'h00); drain();
    end
    tick();
    exp_irq("ovf_irq_hi", 1'b1); exp_rd("ovf_reload", A_TIMA, 8'hAB); drain();
    tick();
    exp_irq("ovf_irq_lo", 1'b0); exp_rd("ovf_hold", A_TIMA, 8'hAB); drain();
    tick(4);

    // TIMA write during DELAY cancels reload and IRQ
    ovf_start(); tick(17); wr(A_TIMA, 8'h10);
    exp_rd("cancel_tima", A_TIMA, 8'h10); drain();
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_irq("cancel_no_irq", 1'b0); exp_rd("cancel_keep", A_TIMA, 8'h10); drain();
    end

    // RELOAD: TIMA write ignored, TMA write also loads TIMA
    ovf_start(); tick(20); tick();
    wr(A_TIMA, 8'h55); exp_rd("reload_tima_ign", A_TIMA, 8'hAB); drain();
    wr(A_TMA, 8'h77);
    exp_rd("reload_tma_tima", A_TIMA, 8'h77); exp_rd("reload_tma", A_TMA, 8'h77); drain();
    tick();
    wr(A_TIMA, 8'h12); exp_rd("run_after_reload", A_TIMA, 8'h12); drain();

    // TMA write during DELAY feeds the reload
    ovf_start(); tick(17); wr(A_TMA, 8'hCD);
    tick(); exp_rd("delay_tma_e20", A_TIMA, 8'h00); drain();
    tick(); exp_irq("delay_tma_irq", 1'b1); exp_rd("delay_tma_reload", A_TIMA, 8'hCD); drain();
    tick(5);

    // DIV write while the TAC=04 tap is high glitches TIMA
    align(8'h20); wr(A_TAC, 8'h04);
    tick(599); exp_rd("gdiv_pre", A_TIMA, 8'h20); drain();
    wr(A_DIV, 8'h5A);
    exp_rd("gdiv_div0", A_DIV, 8'h00); exp_rd("gdiv_e601", A_TIMA, 8'h20); drain();
    tick(); exp_rd("gdiv_inc", A_TIMA, 8'h21); drain();

    // TAC disable while the selected bit is high glitches TIMA
    align(8'h30); wr(A_TAC, 8'h05);
    tick(9); wr(A_TAC, 8'h00);
    exp_rd("gtac_e11", A_TIMA, 8'h30); exp_rd("gtac_tac", A_TAC, 8'hF8); drain();
    tick(); exp_rd("gtac_inc", A_TIMA, 8'h31); drain();

    // Async reset in the middle of DELAY
    ovf_start(); tick(18);
    #2; reset = 1'b1; #1;
    exp_irq("arst_irq", 1'b0); exp_rd("arst_tima", A_TIMA, 8'h00);
    exp_rd("arst_tma", A_TMA, 8'h00); exp_rd("arst_tac", A_TAC, 8'hF8); drain();
    tick(); #2; reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_irq("arst_post_irq", 1'b0); exp_rd("arst_post_tima", A_TIMA, 8'h00); drain();
    end

    rd(A_TAC, d);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
